wide_add_seq: RTL and testbench
===============================

Name: wide_add_seq

Overview:
Multi-cycle sequencer that adds or subtracts two WIDTH-bit operands by reusing one 4-bit ripple-add slice, one nibble per clock, LSB nibble first.
- Input side: valid/ready operand port.
- Output side: valid/ready result port.
- Sits between operand producers and result consumers wherever a wide adder is too costly in area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NIB (localparam), WIDTH/4, number of nibble steps per operation
CNT_W (localparam), max(1, clog2(NIB)), step counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request
in_ready  output  1  operand accept; a transfer occurs when in_valid & in_ready at a rising edge
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in (add mode only)
in_sub  input  1  1 = A - B, 0 = A + B + cin
out_valid  output  1  result available
out_ready  input  1  consumer accept
out_sum  output  WIDTH  result
out_cout  output  1  carry-out; in subtract mode, 1 = no borrow
busy  output  1  high in RUN state

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values:
  - state = IDLE; out_valid = 0, out_sum = 0, out_cout = 0, busy = 0.
  - Operand, carry and counter registers = 0.
  - Inputs are ignored while rst_n is low.
- States:
  - IDLE: waiting for operands.
  - RUN: one nibble per cycle.
  - DONE: result held.
- in_ready (combinational) = (state == IDLE) | (state == DONE & out_ready).
- Accept (in_valid & in_ready):
  - Latch a_reg = in_a.
  - Latch b_reg = in_sub ? ~in_b : in_b.
  - carry = in_sub ? 1 : in_cin.
  - cnt = 0; state -> RUN; out_valid drops to 0 on the same edge.
- RUN, every edge:
  - Slice adds a_reg[3:0] + b_reg[3:0] + carry.
  - a_reg and b_reg shift right by 4.
  - Sum nibble enters the result register at the top, which shifts right by 4.
  - carry <= slice carry-out; cnt increments.
- On the edge where cnt == NIB-1:
  - state -> DONE; out_valid = 1.
  - out_sum = assembled result; out_cout = final carry.
- Latency: out_valid rises exactly NIB edges after the accepting edge. Throughput is one operation per NIB+1 cycles with continuous valid/ready.
- DONE:
  - out_sum and out_cout stay stable while out_valid = 1 and out_ready = 0.
  - On out_ready: if in_valid is also high, the new operands are accepted on the same edge (state -> RUN); otherwise state -> IDLE and out_valid -> 0.
- WIDTH = 4: RUN lasts 1 cycle; the counter is unused.
- in_valid during RUN is ignored (in_ready = 0); no operand is lost or corrupted.
- Reset asserted mid-RUN or mid-DONE aborts immediately to the reset values; the partial result is discarded.
- Arithmetic is modulo 2^WIDTH; the carry chain spans nibble boundaries only through the carry register.

Optional Feature:
WADD_OVF_EN
- Defined:
  - Adds output port out_ovf (1 bit), the two's-complement signed overflow = carry-into-MSB XOR final carry-out.
  - Carry-into-MSB is derived in the last nibble step.
  - Registered alongside out_sum; reset 0; held stable in DONE.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package wadd_pkg:
  - state typedef (IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10).
  - NIB_W = 4 constant.
- One natural sub-module, nibble_add4: combinational 4-bit ripple slice (a, b, cin -> sum, cout, c3 = carry into bit 3 for overflow). Instantiated once.
- Controller FSM, counter and shift registers live in wide_add_seq.

Test Plan:
- WIDTH=16, add 0x1234 + 0x0FFF, cin=0 -> out_sum=0x2233, out_cout=0; out_valid exactly 4 edges after accept; busy high for 4 cycles.
- Add 0xFFFF + 0x0001, cin=0 -> 0x0000, cout=1 (carry ripples through all nibbles). Add 0x0000 + 0x0000, cin=1 -> 0x0001, cout=0.
- Subtract 0x0005 - 0x0007 -> 0xFFFE, cout=0. Subtract 0x0007 - 0x0005 -> 0x0002, cout=1; in_cin toggled during both operations has no effect.
- Backpressure: result 0x2233 held with out_ready=0 for 10 cycles while in_valid=1 (new op 0x0001+0x0001):
  - in_ready stays 0; out_sum stays stable.
  - When out_ready=1, the new op is accepted on the same edge; 0x0002 appears 4 edges later.
- Reset: assert rst_n=0 during RUN at cnt=2 -> out_valid, out_sum, busy = 0 asynchronously. After release, 0x00FF + 0x0001 -> 0x0100.
- With WADD_OVF_EN:
  - 0x7FFF + 0x0001 -> 0x8000, ovf=1.
  - 0x8000 - 0x0001 -> 0x7FFF, ovf=1.
  - 0x0003 + 0x0004 -> ovf=0.

Source files
------------

// File: rtl/wide_add_seq_pkg.sv
// Shared types and constants for the nibble-serial wide adder (package wadd_pkg).
package wadd_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/wide_add_seq_nibble_add4.sv
// Combinational 4-bit ripple slice; c3 is the carry into the top bit, used
// for signed overflow detection on the most significant nibble.
module nibble_add4
  import wadd_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout,
  output logic             c3
);

  logic [NIB_W:0] chain;

  always_comb begin
    chain    = '0;
    sum      = '0;
    chain[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ chain[i];
      chain[i+1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = chain[NIB_W];
  assign c3   = chain[NIB_W-1];

endmodule

// File: rtl/wide_add_seq.sv
// Nibble-serial WIDTH-bit add/subtract sequencer reusing one 4-bit slice.
// Optional signed-overflow output enabled by defining WADD_OVF_EN.
module wide_add_seq
  import wadd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef WADD_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("wide_add_seq: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             accept;

  logic [NIB_W-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_c3;

  nibble_add4 u_slice (
    .a    (a_reg[NIB_W-1:0]),
    .b    (b_reg[NIB_W-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign last      = (cnt == CNT_W'(NIB - 1));

  // New nibble enters at the top so the LSB nibble lands at bit 0 after NIB steps
  assign res_next = (res_reg >> NIB_W) | (WIDTH'(slice_sum) << (WIDTH - NIB_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (last) state_next = DONE;
      DONE: begin
        if (accept) begin
          state_next = RUN;
        end else if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage boundary: operand capture on accept, one nibble per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_sub ? ~in_b : in_b;
      carry <= in_sub ? 1'b1 : in_cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_reg   <= a_reg >> NIB_W;
      b_reg   <= b_reg >> NIB_W;
      res_reg <= res_next;
      carry   <= slice_cout;
      cnt     <= cnt + CNT_W'(1);
      if (last) begin
        out_sum  <= res_next;
        out_cout <= slice_cout;
      end
    end
  end

`ifdef WADD_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ovf <= 1'b0;
    end else if (!accept && state == RUN && last) begin
      out_ovf <= slice_c3 ^ slice_cout;
    end
  end
`else
  logic unused_c3;
  assign unused_c3 = slice_c3;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed self-checking bench for wide_add_seq at WIDTH=16.
module tb_wide_add_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  int checks;
  int failures;

  wide_add_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef WADD_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

`ifndef WADD_OVF_EN
  assign out_ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation from IDLE, optionally wiggling inputs during RUN,
  // and returns the captured result plus latency and busy-cycle counts.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic noise,
                        output logic [15:0] sum, output logic cout,
                        output logic ovf, output int lat, output int busy_cnt);
    int guard;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      if (noise) begin
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'($urandom);
        in_cin = ~in_cin; in_sub = ~in_sub;
      end
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    sum = out_sum; cout = out_cout; ovf = out_ovf;
    if (!out_valid) lat = 99;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", out_sum); end
    checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", out_cout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    logic [15:0] s; logic c; logic o; int lat; int bc;
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, s, c, o, lat, bc);
    checks++; if (s !== 16'h2233) begin failures++; $display("FAIL add1_sum got=%h exp=2233", s); end
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL add1_cout got=%b exp=0", c); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL add1_latency got=%0d exp=4", lat); end
    checks++; if (bc !== 4) begin failures++; $display("FAIL add1_busy_cycles got=%0d exp=4", bc); end
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, s, c, o, lat, bc);
    checks++; if (s !== 16'h0000) begin failures++; $display("FAIL add2_sum got=%h exp=0000", s); end
    checks++; if (c !== 1'b1) begin failures++; $display("FAIL add2_cout got=%b exp=1", c); end
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, s, c, o, lat, bc);
    checks++; if (s !== 16'h0001) begin failures++; $display("FAIL add3_sum got=%h exp=0001", s); end
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL add3_cout got=%b exp=0", c); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_after_ready got=%b exp=0", out_valid); end
  endtask

  task automatic test_sub();
    logic [15:0] s; logic c; logic o; int lat; int bc;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, s, c, o, lat, bc);
    checks++; if (s !== 16'hFFFE) begin failures++; $display("FAIL sub1_sum got=%h exp=fffe", s); end
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL sub1_cout got=%b exp=0", c); end
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, s, c, o, lat, bc);
    checks++; if (s !== 16'h0002) begin failures++; $display("FAIL sub2_sum got=%h exp=0002", s); end
    checks++; if (c !== 1'b1) begin failures++; $display("FAIL sub2_cout got=%b exp=1", c); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL sub2_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_back_to_back();
    int guard; int lat;
    in_a = 16'h1234; in_b = 16'h0FFF; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 16'h0001; in_b = 16'h0001;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_timeout got=%b exp=1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_sum !== 16'h2233) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=2233", i, out_sum); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_reaccept busy=%b valid=%b exp busy=1 valid=0", busy, out_valid); end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    checks++; if (out_sum !== 16'h0002) begin failures++; $display("FAIL bp_sum got=%h exp=0002", out_sum); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] s; logic c; logic o; int lat; int bc;
    in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== 16'h0000) begin failures++; $display("FAIL rst_async_sum got=%h exp=0000", out_sum); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, s, c, o, lat, bc);
    checks++; if (s !== 16'h0100) begin failures++; $display("FAIL rst_after_sum got=%h exp=0100", s); end
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL rst_after_cout got=%b exp=0", c); end
  endtask

`ifdef WADD_OVF_EN
  task automatic test_ovf();
    logic [15:0] s; logic c; logic o; int lat; int bc;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, s, c, o, lat, bc);
    checks++; if (s !== 16'h8000 || o !== 1'b1) begin failures++; $display("FAIL ovf1 sum=%h ovf=%b exp sum=8000 ovf=1", s, o); end
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, s, c, o, lat, bc);
    checks++; if (s !== 16'h7FFF || o !== 1'b1) begin failures++; $display("FAIL ovf2 sum=%h ovf=%b exp sum=7fff ovf=1", s, o); end
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, s, c, o, lat, bc);
    checks++; if (s !== 16'h0007 || o !== 1'b0) begin failures++; $display("FAIL ovf3 sum=%h ovf=%b exp sum=0007 ovf=0", s, o); end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
`ifdef WADD_OVF_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
